// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter sharing a single-port, word-addressed data memory
//   between port 0 (core load/store unit) and port 1 (DMA / program loader).
//   One word access per granted cycle; read data is registered back to the
//   port that won the read.
//
// Optional feature macro: DMEM_ARB_LOCK_EN
//   When defined, each port gets a pN_lock_i input. A granted port holding
//   lock keeps exclusive ownership until it completes a grant with lock low,
//   or until LOCK_MAX cycles have elapsed (forced release).
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   pN_req_i / pN_we_i         port N request / write enable (0 = read)
//   pN_mask_i                  port N byte-lane write mask (4 lanes)
//   pN_addr_i / pN_wdata_i     port N word address / write data
//   pN_lock_i                  port N hold-grant request (lock build only)
//   pN_gnt_o                   port N access performed this cycle (comb)
//   pN_rvalid_o / pN_rdata_o   port N registered read response
//   mem_cs_o / mem_we_o        memory chip select / write enable
//   mem_mask_o / mem_addr_o    memory byte mask / word address
//   mem_wdata_o / mem_rdata_i  memory write data / combinational read data

module dmem_arbiter #(
    parameter int unsigned DW    = 32,
    parameter int unsigned ADDRW = 8
`ifdef DMEM_ARB_LOCK_EN
    ,
    parameter int unsigned LOCK_MAX = 16
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             p0_req_i,
    input  logic             p0_we_i,
    input  logic [3:0]       p0_mask_i,
    input  logic [ADDRW-1:0] p0_addr_i,
    input  logic [DW-1:0]    p0_wdata_i,
`ifdef DMEM_ARB_LOCK_EN
    input  logic             p0_lock_i,
`endif
    output logic             p0_gnt_o,
    output logic             p0_rvalid_o,
    output logic [DW-1:0]    p0_rdata_o,

    input  logic             p1_req_i,
    input  logic             p1_we_i,
    input  logic [3:0]       p1_mask_i,
    input  logic [ADDRW-1:0] p1_addr_i,
    input  logic [DW-1:0]    p1_wdata_i,
`ifdef DMEM_ARB_LOCK_EN
    input  logic             p1_lock_i,
`endif
    output logic             p1_gnt_o,
    output logic             p1_rvalid_o,
    output logic [DW-1:0]    p1_rdata_o,

    output logic             mem_cs_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_mask_o,
    output logic [ADDRW-1:0] mem_addr_o,
    output logic [DW-1:0]    mem_wdata_o,
    input  logic [DW-1:0]    mem_rdata_i
);

    // last_q = port granted most recently; on a tie the other port wins.
    logic          last_q, last_d;
    logic          gnt0, gnt1;
    logic          arb_g0, arb_g1;
    logic          p0_rvalid_q, p1_rvalid_q;
    logic [DW-1:0] p0_rdata_q, p1_rdata_q;

    assign arb_g0 = p0_req_i & (~p1_req_i | last_q);
    assign arb_g1 = p1_req_i & (~p0_req_i | ~last_q);

`ifdef DMEM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    localparam int unsigned CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    // Release is decided on the incremented count, so a lock owns the
    // memory for LOCK_MAX cycles including the ARB cycle that took it.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_ARB: begin
                gnt0  = arb_g0;
                gnt1  = arb_g1;
                cnt_d = '0;
                if (arb_g0 && p0_lock_i) begin
                    state_d = ST_LOCK0;
                end else if (arb_g1 && p1_lock_i) begin
                    state_d = ST_LOCK1;
                end
            end
            ST_LOCK0: begin
                gnt0  = p0_req_i;
                cnt_d = cnt_inc;
                if ((p0_req_i && !p0_lock_i) || (cnt_inc == CNT_LAST)) begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end
            end
            ST_LOCK1: begin
                gnt1  = p1_req_i;
                cnt_d = cnt_inc;
                if ((p1_req_i && !p1_lock_i) || (cnt_inc == CNT_LAST)) begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_ARB;
                cnt_d   = '0;
            end
        endcase
        if (rst_i) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_ARB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    always_comb begin
        gnt0   = arb_g0 & ~rst_i;
        gnt1   = arb_g1 & ~rst_i;
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end
`endif

    // Memory command mux: winner's fields, all zero when nobody is granted.
    always_comb begin
        mem_cs_o    = gnt0 | gnt1;
        mem_we_o    = 1'b0;
        mem_mask_o  = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt0) begin
            mem_we_o    = p0_we_i;
            mem_mask_o  = p0_mask_i;
            mem_addr_o  = p0_addr_i;
            mem_wdata_o = p0_wdata_i;
        end else if (gnt1) begin
            mem_we_o    = p1_we_i;
            mem_mask_o  = p1_mask_i;
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q      <= 1'b1;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            last_q      <= last_d;
            p0_rvalid_q <= gnt0 & ~p0_we_i;
            p1_rvalid_q <= gnt1 & ~p1_we_i;
            if (gnt0 && !p0_we_i) begin
                p0_rdata_q <= mem_rdata_i;
            end
            if (gnt1 && !p1_we_i) begin
                p1_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign p0_gnt_o    = gnt0;
    assign p1_gnt_o    = gnt1;
    assign p0_rvalid_o = p0_rvalid_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;

endmodule
